// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that grants one requester at a time the shared output
// channel and drives the data mux select until end-of-packet or stall timeout.
module mux_rr_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned STALL_MAX = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        last,
  input  logic [N_REQ*DATA_W-1:0] data_in,
  input  logic                    out_ready,
  output logic [N_REQ-1:0]        grant,
  output logic [SEL_W-1:0]        sel,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_last,
  output logic                    busy
);

  localparam int unsigned CNT_W = $clog2(STALL_MAX + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic               busy_q, busy_d;

  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic               stall_hit;
  logic [DATA_W-1:0]  slice [N_REQ];

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      slice[i] = data_in[i*DATA_W +: DATA_W];
    end
  end

  assign out_data  = slice[sel_q];
  assign out_valid = busy_q & req[sel_q];
  assign out_last  = out_valid & last[sel_q];
  assign grant     = grant_q;
  assign sel       = sel_q;
  assign busy      = busy_q;

  // Search ptr, ptr+1, ... ; SEL_W-bit addition wraps modulo N_REQ.
  always_comb begin
    logic [SEL_W-1:0] cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = ptr_q + SEL_W'(k);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    stall_d   = stall_q;
    stall_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = OWN;
          grant_d = N_REQ'(1) << pick_idx;
          sel_d   = pick_idx;
          stall_d = '0;
        end
      end
      OWN: begin
        if (req[sel_q]) begin
          stall_d = '0;
        end else if (stall_q != CNT_W'(STALL_MAX)) begin
          stall_d = stall_q + 1'b1;
        end
        stall_hit = !req[sel_q] && (stall_q == CNT_W'(STALL_MAX - 1));
        // End-of-packet and stall timeout share one release path, so ptr advances once.
        if ((out_last && out_ready) || stall_hit) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = sel_q + SEL_W'(1);
          stall_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == OWN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      stall_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      stall_q <= stall_d;
      busy_q  <= busy_d;
    end
  end

endmodule
